// File: rtl/score_event_scheduler_if.sv
// Event/ALU handshake bundle for score_event_scheduler: requester pulses and
// controls in, ALU strobe/op code and status flags out.
interface score_event_scheduler_if;
    logic [3:0] req;
    logic       pause;
    logic       clr_ovf;
    logic       alu_enable;
    logic [1:0] alu_select;
    logic       busy;
    logic [3:0] ovf;

    modport master (
        output req, pause, clr_ovf,
        input  alu_enable, alu_select, busy, ovf
    );

    modport slave (
        input  req, pause, clr_ovf,
        output alu_enable, alu_select, busy, ovf
    );
endinterface

// File: rtl/score_event_scheduler.sv
// Queues score events from four requesters and issues at most one ALU op per slot.
// Define SCORE_SCHED_RR_EN for round-robin arbitration; otherwise fixed priority (0 highest).
module score_event_scheduler #(
    parameter int CNT_W = 4,
    parameter int GAP   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    score_event_scheduler_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam int              HOLD_W  = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]  cnt [4];
    logic [3:0]        ovf_q;
    logic [1:0]        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              alu_enable_q;
    logic [1:0]        alu_select_q;

    logic [3:0] nonempty;
    logic [3:0] dec_vec;
    logic [3:0] ovf_set;
    logic       eval_slot;
    logic       found;
    logic       grant;
    logic [1:0] grant_idx;

    // NOTE: every signal driven from always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        nonempty = '0;
        for (int i = 0; i < 4; i++) begin
            nonempty[i] = (cnt[i] != '0);
        end
    end

    // A grant slot opens in IDLE, in ISSUE when back-to-back issue is allowed,
    // and on the last HOLD cycle (countdown reaching zero re-evaluates as IDLE).
    always_comb begin
        eval_slot = 1'b1;
        case (state)
            ST_ISSUE: eval_slot = (GAP == 0);
            ST_HOLD:  eval_slot = (hold_cnt <= HOLD_W'(1));
            default:  eval_slot = 1'b1;
        endcase
    end

`ifdef SCORE_SCHED_RR_EN
    logic [1:0] rr_ptr;
    logic [1:0] cand;

    always_comb begin
        found     = 1'b0;
        grant_idx = rr_ptr;
        cand      = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!found && nonempty[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= 2'd3;
        end else if (grant) begin
            rr_ptr <= grant_idx;
        end
    end
`else
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 3; k >= 0; k--) begin
            if (nonempty[k]) begin
                found     = 1'b1;
                grant_idx = 2'(k);
            end
        end
    end
`endif

    assign grant = eval_slot && !bus.pause && found;

    // A request and a grant on the same edge cancel; only an uncancelled
    // request against a full counter is a dropped event.
    always_comb begin
        dec_vec = '0;
        ovf_set = '0;
        for (int i = 0; i < 4; i++) begin
            dec_vec[i] = grant && (grant_idx == 2'(i));
            ovf_set[i] = bus.req[i] && !dec_vec[i] && (cnt[i] == CNT_MAX);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            hold_cnt     <= '0;
            alu_enable_q <= 1'b0;
            alu_select_q <= 2'b00;
        end else begin
            alu_enable_q <= grant;
            if (grant) begin
                alu_select_q <= grant_idx;
            end
            case (state)
                ST_HOLD: begin
                    if (hold_cnt > HOLD_W'(1)) begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end else begin
                        hold_cnt <= '0;
                        state    <= grant ? ST_ISSUE : ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (GAP > 0) begin
                        state    <= ST_HOLD;
                        hold_cnt <= HOLD_W'(GAP);
                    end else begin
                        state <= grant ? ST_ISSUE : ST_IDLE;
                    end
                end
                default: state <= grant ? ST_ISSUE : ST_IDLE;
            endcase
        end
    end

    // NOTE: the pending counters are a tiny register array, not a RAM, so they
    // are reset explicitly; reset must discard every queued event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req[i] && !dec_vec[i] && (cnt[i] != CNT_MAX)) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dec_vec[i] && !bus.req[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
            ovf_q <= ovf_set | (bus.clr_ovf ? 4'b0000 : ovf_q);
        end
    end

    assign bus.alu_enable = alu_enable_q;
    assign bus.alu_select = alu_select_q;
    assign bus.busy       = (|nonempty) | alu_enable_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_score_event_scheduler.sv
// Scoreboard bench for score_event_scheduler: a GAP=0 instance checked through an
// op-code queue, plus a GAP=2 instance checked cycle by cycle.
module tb_score_event_scheduler;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    score_event_scheduler_if bus0 ();
    score_event_scheduler_if bus_g ();

    score_event_scheduler #(.CNT_W(4), .GAP(0)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    score_event_scheduler #(.CNT_W(4), .GAP(2)) u_gap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_g)
    );

    int         n_vec    = 0;
    int         n_err    = 0;
    int         n_strobe = 0;
    logic [1:0] sb_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every strobe on the GAP=0 instance must match the next queued op code.
    always @(negedge clk) begin
        if (!reset && bus0.alu_enable === 1'b1) begin
            n_strobe++;
            check("strobe_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                check("alu_select", 32'(bus0.alu_select), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         s0;
        logic [1:0] exp_seq [8];
        logic       exp_en;

        bus0.req  = '0; bus0.pause  = 1'b0; bus0.clr_ovf  = 1'b0;
        bus_g.req = '0; bus_g.pause = 1'b0; bus_g.clr_ovf = 1'b0;

        // Reset values
        cycles(3);
        check("rst_en",    32'(bus0.alu_enable), 32'd0);
        check("rst_sel",   32'(bus0.alu_select), 32'd0);
        check("rst_busy",  32'(bus0.busy),       32'd0);
        check("rst_ovf",   32'(bus0.ovf),        32'd0);
        check("rst_g_en",  32'(bus_g.alu_enable), 32'd0);
        check("rst_g_busy", 32'(bus_g.busy),     32'd0);
        reset = 1'b0;
        cycles(2);

        // All four sources at once: 0,1,2,3 on consecutive cycles
        for (int i = 0; i < 4; i++) sb_q.push_back(2'(i));
        bus0.req = 4'b1111;
        cycles(1);
        bus0.req = 4'b0000;
        check("all4_e0_en", 32'(bus0.alu_enable), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cycles(1);
            check("all4_back2back_en", 32'(bus0.alu_enable), 32'd1);
        end
        cycles(1);
        check("all4_done_en", 32'(bus0.alu_enable), 32'd0);
        cycles(2);
        check("all4_sb_drained", 32'(sb_q.size()), 32'd0);

        // Sources 0 and 3 held for four cycles
`ifdef SCORE_SCHED_RR_EN
        exp_seq = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3};
`else
        exp_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
        for (int i = 0; i < 8; i++) sb_q.push_back(exp_seq[i]);
        s0 = n_strobe;
        bus0.req = 4'b1001;
        cycles(4);
        bus0.req = 4'b0000;
        cycles(10);
        check("hold03_strobes", 32'(n_strobe - s0), 32'd8);
        check("hold03_sb_drained", 32'(sb_q.size()), 32'd0);
        check("hold03_busy", 32'(bus0.busy), 32'd0);

        // Single event on source 2: strobe E1..E2, busy clear after E2
        sb_q.push_back(2'd2);
        bus0.req = 4'b0100;
        cycles(1);
        bus0.req = 4'b0000;
        check("single_e0_en",   32'(bus0.alu_enable), 32'd0);
        check("single_e0_busy", 32'(bus0.busy),       32'd1);
        cycles(1);
        check("single_e1_en",   32'(bus0.alu_enable), 32'd1);
        check("single_e1_sel",  32'(bus0.alu_select), 32'd2);
        cycles(1);
        check("single_e2_en",   32'(bus0.alu_enable), 32'd0);
        check("single_e2_busy", 32'(bus0.busy),       32'd0);
        cycles(2);
        check("single_sb_drained", 32'(sb_q.size()), 32'd0);

        // GAP=2 instance: three events on source 1 -> strobes at E1, E4, E7
        bus_g.req = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            cycles(1);
            exp_en = (k == 1) || (k == 4) || (k == 7);
            check("gap2_en", 32'(bus_g.alu_enable), 32'(exp_en));
            if (exp_en) check("gap2_sel", 32'(bus_g.alu_select), 32'd1);
            if (k == 2) bus_g.req = 4'b0000;
        end
        check("gap2_busy", 32'(bus_g.busy), 32'd0);

        // Saturation under pause, overflow flag, set-beats-clear, then drain
        bus0.pause = 1'b1;
        bus0.req   = 4'b0100;
        cycles(17);
        bus0.req   = 4'b0000;
        check("sat_ovf",  32'(bus0.ovf),        32'h4);
        check("sat_en",   32'(bus0.alu_enable), 32'd0);
        check("sat_busy", 32'(bus0.busy),       32'd1);
        bus0.req     = 4'b0100;
        bus0.clr_ovf = 1'b1;
        cycles(1);
        bus0.req     = 4'b0000;
        bus0.clr_ovf = 1'b0;
        check("sat_set_wins", 32'(bus0.ovf), 32'h4);
        bus0.clr_ovf = 1'b1;
        cycles(1);
        bus0.clr_ovf = 1'b0;
        check("sat_clr_ovf", 32'(bus0.ovf), 32'h0);
        for (int i = 0; i < 15; i++) sb_q.push_back(2'd2);
        s0 = n_strobe;
        bus0.pause = 1'b0;
        cycles(20);
        check("sat_strobes", 32'(n_strobe - s0), 32'd15);
        check("sat_sb_drained", 32'(sb_q.size()), 32'd0);
        check("sat_busy_end", 32'(bus0.busy), 32'd0);

        // Request on the grant edge keeps the count and yields a second strobe
        sb_q.push_back(2'd0);
        sb_q.push_back(2'd0);
        bus0.req = 4'b0001;
        cycles(1);
        check("same_e0_en", 32'(bus0.alu_enable), 32'd0);
        cycles(1);
        bus0.req = 4'b0000;
        check("same_e1_en", 32'(bus0.alu_enable), 32'd1);
        cycles(1);
        check("same_e2_en", 32'(bus0.alu_enable), 32'd1);
        cycles(1);
        check("same_e3_en",   32'(bus0.alu_enable), 32'd0);
        check("same_e3_busy", 32'(bus0.busy),       32'd0);
        check("same_sb_drained", 32'(sb_q.size()), 32'd0);

        // Reset mid-burst with three events pending on source 0
        bus0.pause = 1'b1;
        bus0.req   = 4'b0001;
        cycles(3);
        bus0.req   = 4'b0000;
        bus0.pause = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_pre_en", 32'(bus0.alu_enable), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rstmid_en_drop", 32'(bus0.alu_enable), 32'd0);
        check("rstmid_busy",    32'(bus0.busy),       32'd0);
        @(negedge clk);
        reset = 1'b0;
        s0 = n_strobe;
        cycles(10);
        check("rstmid_no_strobes", 32'(n_strobe - s0), 32'd0);
        check("rstmid_en",    32'(bus0.alu_enable),  32'd0);
        check("rstmid_sel",   32'(bus0.alu_select),  32'd0);
        check("rstmid_g_sel", 32'(bus_g.alu_select), 32'd0);
        check("rstmid_busy2", 32'(bus0.busy),        32'd0);
        check("rstmid_ovf",   32'(bus0.ovf),         32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
